// File: rtl/serial_scheduler.sv
// Round-robin scheduler sharing one Serial transmitter between N_REQ message sources.
// Runs the four-phase START/END handshake and aborts a transfer whose END never arrives.
module serial_scheduler #(
  parameter int N_REQ   = 4,
  parameter int GRANT_W = 2,
  parameter int WIDTH   = 40,
  parameter int TIMEOUT = 4000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic [GRANT_W-1:0]       grant_id,
  output logic                     timeout_err,
  output logic                     ser_start,
  output logic [WIDTH-1:0]         ser_buffer,
  input  logic                     ser_end
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [GRANT_W-1:0]   ptr, ptr_nxt, win, gid_nxt;
  logic [31:0]          wdog, wdog_nxt;
  logic [N_REQ-1:0]     ack_nxt;
  logic [WIDTH-1:0]     buf_nxt;
  logic                 start_nxt, err_nxt, any_req, timeout_hit;

  // First set request at or above the pointer, wrapping past N_REQ-1.
  function automatic logic [GRANT_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [GRANT_W-1:0] p);
    int   idx;
    logic found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        rr_pick = GRANT_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] w);
    wrap_inc = (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] w);
    sat_inc = (w == '1) ? w : w + 32'd1;
  endfunction

  assign any_req     = |req;
  assign win         = rr_pick(req, ptr);
  assign timeout_hit = (TIMEOUT != 0) && (wdog == 32'(TIMEOUT - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SEND;
      SEND:    if (ser_end || timeout_hit) state_nxt = RELEASE;
      RELEASE: if (!ser_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; an END on the timeout cycle takes priority.
  always_comb begin
    start_nxt = ser_start;
    ack_nxt   = '0;
    err_nxt   = timeout_err;
    buf_nxt   = ser_buffer;
    gid_nxt   = grant_id;
    ptr_nxt   = ptr;
    wdog_nxt  = wdog;
    case (state)
      IDLE: begin
        if (any_req) begin
          buf_nxt   = data[int'(win)*WIDTH +: WIDTH];
          gid_nxt   = win;
          start_nxt = 1'b1;
          ptr_nxt   = wrap_inc(win);
          wdog_nxt  = '0;
        end
      end
      SEND: begin
        wdog_nxt = sat_inc(wdog);
        if (ser_end) begin
          start_nxt         = 1'b0;
          ack_nxt[grant_id] = 1'b1;
        end else if (timeout_hit) begin
          start_nxt = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      RELEASE: start_nxt = 1'b0;
      default: start_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_start   <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      ser_buffer  <= '0;
      grant_id    <= '0;
      ptr         <= '0;
      wdog        <= '0;
    end else begin
      ser_start   <= start_nxt;
      ack         <= ack_nxt;
      timeout_err <= err_nxt;
      ser_buffer  <= buf_nxt;
      grant_id    <= gid_nxt;
      ptr         <= ptr_nxt;
      wdog        <= wdog_nxt;
    end
  end

endmodule
